// File: rtl/ecg_nn_pkg.sv
// Shared definitions for the ECG network's classification stages.
// Holds the default vector geometry and the argmax FSM state encoding.
package ecg_nn_pkg;

    localparam int DEFAULT_NUM_CLASSES = 4;
    localparam int DEFAULT_DATA_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/argmax_cmp_step.sv
// One step of the sequential argmax scan: folds element (elem, idx) into the
// running (max, class, tie) triple. Purely combinational.
module argmax_cmp_step
    import ecg_nn_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IDX_W  = 2
) (
    input  logic [DATA_W-1:0] elem,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] cur_max,
    input  logic [IDX_W-1:0]  cur_class,
    input  logic              cur_tie,
    output logic [DATA_W-1:0] nxt_max,
    output logic [IDX_W-1:0]  nxt_class,
    output logic              nxt_tie
);

    // Strictly-greater keeps the lower index on ties.
    always_comb begin
        nxt_max   = cur_max;
        nxt_class = cur_class;
        nxt_tie   = cur_tie;
        if (idx == '0) begin
            nxt_max   = elem;
            nxt_class = idx;
            nxt_tie   = 1'b0;
        end else if (elem > cur_max) begin
            nxt_max   = elem;
            nxt_class = idx;
            nxt_tie   = 1'b0;
        end else if (elem == cur_max) begin
            nxt_tie   = 1'b1;
        end
    end

endmodule

// File: rtl/layer_argmax_classifier.sv
// Final ECG classification stage: captures one vector of node outputs, scans it
// one element per cycle and presents class index, score, tie flag and sequence number.
module layer_argmax_classifier
    import ecg_nn_pkg::*;
#(
    parameter int  NUM_CLASSES = DEFAULT_NUM_CLASSES,
    parameter int  DATA_W      = DEFAULT_DATA_W,
    parameter int  SEQ_W       = 8,
    localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CLASSES*DATA_W-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              out_class,
    output logic [DATA_W-1:0]             out_score,
    output logic                          out_tie,
    output logic [SEQ_W-1:0]              out_seq
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t state_q, state_d;

    logic [DATA_W-1:0] bank_q [NUM_CLASSES];
    logic [DATA_W-1:0] bank_d [NUM_CLASSES];
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [DATA_W-1:0] scan_max_q, scan_max_d;
    logic [IDX_W-1:0]  scan_class_q, scan_class_d;
    logic              scan_tie_q, scan_tie_d;

    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  out_class_q, out_class_d;
    logic [DATA_W-1:0] out_score_q, out_score_d;
    logic              out_tie_q, out_tie_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;

    logic [DATA_W-1:0] step_max;
    logic [IDX_W-1:0]  step_class;
    logic              step_tie;
    logic              accept;

    argmax_cmp_step #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_step (
        .elem      (bank_q[idx_q]),
        .idx       (idx_q),
        .cur_max   (scan_max_q),
        .cur_class (scan_class_q),
        .cur_tie   (scan_tie_q),
        .nxt_max   (step_max),
        .nxt_class (step_class),
        .nxt_tie   (step_tie)
    );

    // In DONE the slot frees on the same edge the consumer takes the result.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        idx_d        = idx_q;
        scan_max_d   = scan_max_q;
        scan_class_d = scan_class_q;
        scan_tie_d   = scan_tie_q;
        out_valid_d  = out_valid_q;
        out_class_d  = out_class_q;
        out_score_d  = out_score_q;
        out_tie_d    = out_tie_q;
        seq_d        = seq_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                scan_max_d   = step_max;
                scan_class_d = step_class;
                scan_tie_d   = step_tie;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_class_d = step_class;
                    out_score_d = step_max;
                    out_tie_d   = step_tie;
                end
            end
            DONE: begin
                if (out_ready) begin
                    seq_d       = seq_q + SEQ_W'(1);
                    out_valid_d = 1'b0;
                    state_d     = in_valid ? SCAN : IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // New vectors are only sampled on the accepting edge.
        if (accept) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                bank_d[i] = in_data[i*DATA_W +: DATA_W];
            end
            idx_d        = '0;
            scan_max_d   = '0;
            scan_class_d = '0;
            scan_tie_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                bank_q[i] <= '0;
            end
            idx_q        <= '0;
            scan_max_q   <= '0;
            scan_class_q <= '0;
            scan_tie_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_class_q  <= '0;
            out_score_q  <= '0;
            out_tie_q    <= 1'b0;
            seq_q        <= '0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            idx_q        <= idx_d;
            scan_max_q   <= scan_max_d;
            scan_class_q <= scan_class_d;
            scan_tie_q   <= scan_tie_d;
            out_valid_q  <= out_valid_d;
            out_class_q  <= out_class_d;
            out_score_q  <= out_score_d;
            out_tie_q    <= out_tie_d;
            seq_q        <= seq_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_score = out_score_q;
    assign out_tie   = out_tie_q;
    assign out_seq   = seq_q;

endmodule
